uart_tx_drain: RTL and testbench



---
 rtl/io881_uart_pkg.sv | 13 +
 rtl/uart_baud_div.sv | 16 +
 rtl/uart_tx_drain.sv | 99 +++++++++
 tb/tb_uart_tx_drain.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/io881_uart_pkg.sv
// io881_uart_pkg: transmitter state encoding and serial line-level constants.
package io881_uart_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;
   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_baud_div.sv
// uart_baud_div: loadable down-counter that reloads itself and flags terminal count at zero.
module uart_baud_div #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [W-1:0] load_val_i,
   output logic         tc_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign tc_o = cnt_q == '0;
   always_comb cnt_d = load_i ? load_val_i : !en_i ? cnt_q : tc_o ? load_val_i : cnt_q - 1'b1;
   always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops FIFO words and shifts them out as async frames on txd.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_drain
   import io881_uart_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] q,
   input  logic             q_ready,
   output logic             q_out_strobe,
   input  logic             cts_n,
   output logic             txd,
   output logic             busy
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(WIDTH + 1);
   uart_state_e      state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [BW-1:0]    bit_q;
   logic             txd_q, busy_q, tc;
`ifdef UART_TX_PARITY_EN
   logic             par_q;
`endif
   assign q_out_strobe = state_q == IDLE && q_ready && !cts_n && !reset;
   assign txd  = txd_q;
   assign busy = busy_q;
   uart_baud_div #(.W(DW)) u_div (
      .clk        (clk),
      .reset      (reset),
      .load_i     (q_out_strobe),
      .en_i       (state_q != IDLE),
      .load_val_i (DW'(CLK_DIV - 1)),
      .tc_o       (tc)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         bit_q   <= '0;
         txd_q   <= IDLE_LVL;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (q_out_strobe) begin
               state_q <= START;
               shreg_q <= q;
               bit_q   <= '0;
               txd_q   <= START_BIT;
               busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
               par_q   <= ^q;
`endif
            end
            START: if (tc) begin
               state_q <= DATA;
               txd_q   <= shreg_q[0];
               shreg_q <= shreg_q >> 1;
            end
            DATA: if (tc) begin
               if (bit_q == BW'(WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_q <= PARITY;
                  txd_q   <= par_q;
`else
                  state_q <= STOP;
                  txd_q   <= STOP_BIT;
`endif
               end else begin
                  txd_q   <= shreg_q[0];
                  shreg_q <= shreg_q >> 1;
                  bit_q   <= bit_q + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tc) begin
               state_q <= STOP;
               txd_q   <= STOP_BIT;
            end
`endif
            STOP: if (tc) begin
               state_q <= IDLE;
               txd_q   <= IDLE_LVL;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               txd_q   <= IDLE_LVL;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: table, corner-case and random checks of uart_tx_drain against a frame-level model.
module tb_uart_tx_drain;
   localparam int W  = 8;
   localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NB = 2 + W + P;
   localparam int F  = NB * CD;

   logic         clk = 1'b0, reset = 1'b1, q_ready = 1'b0, cts_n = 1'b1;
   logic [W-1:0] q = '0;
   logic         q_out_strobe, txd, busy;

   always #5 clk = ~clk;

   uart_tx_drain #(.WIDTH(W), .CLK_DIV(CD)) dut (
      .clk          (clk),
      .reset        (reset),
      .q            (q),
      .q_ready      (q_ready),
      .q_out_strobe (q_out_strobe),
      .cts_n        (cts_n),
      .txd          (txd),
      .busy         (busy)
   );

   typedef struct {
      logic [W-1:0] word;
      logic         par;
   } vec_t;
   vec_t vecs [8];

   int            errs = 0, checks = 0, cyc_n = 0, rem = 0;
   logic [NB-1:0] fbits = '1;
   logic [W-1:0]  fifo [$];
   bit            txlog [$], busylog [$];
   int            strobes [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
      end
   endtask

   function automatic logic [NB-1:0] frame(input logic [W-1:0] w);
      logic [NB-1:0] f;
      f = '0;
      f[0] = 1'b0;
      for (int i = 0; i < W; i++) f[1+i] = w[i];
`ifdef UART_TX_PARITY_EN
      f[W+1] = ^w;
`endif
      f[NB-1] = 1'b1;
      return f;
   endfunction

   task automatic sync_q();
      q_ready = fifo.size() != 0;
      q = q_ready ? fifo[0] : '0;
   endtask

   // Model: rem counts remaining busy cycles of the current frame; 0 means idle.
   task automatic cyc();
      logic exp_s, exp_txd, pop;
      @(negedge clk);
      exp_s   = rem == 0 && fifo.size() != 0 && !cts_n && !reset;
      exp_txd = rem == 0 ? 1'b1 : fbits[(F - rem) / CD];
      chk("strobe", q_out_strobe, exp_s);
      chk("txd", txd, exp_txd);
      chk("busy", busy, rem != 0);
      txlog.push_back(txd);
      busylog.push_back(busy);
      pop = q_out_strobe;
      if (pop) strobes.push_back(cyc_n);
      @(posedge clk);
      #1;
      if (reset) rem = 0;
      else if (rem > 0) rem--;
      else if (exp_s) begin
         fbits = frame(fifo[0]);
         rem = F;
      end
      if (pop && fifo.size() != 0) void'(fifo.pop_front());
      sync_q();
      cyc_n++;
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   function automatic logic sample(input int i);
      return (i >= 0 && i < txlog.size()) ? txlog[i] : 1'bx;
   endfunction

   task automatic decode(input int from, output logic [W-1:0] d, output logic p, output logic stp,
                         output int s, output int blen);
      s = -1;
      d = '0;
      p = 1'b0;
      stp = 1'b0;
      blen = 0;
      for (int i = from; i < txlog.size(); i++) if (txlog[i] == 1'b0) begin
         s = i;
         break;
      end
      if (s < 0) return;
      for (int k = 0; k < W; k++) d[k] = sample(s + (1 + k) * CD + CD / 2);
      p   = sample(s + (1 + W) * CD + CD / 2);
      stp = sample(s + (NB - 1) * CD + CD / 2);
      for (int i = s; i < busylog.size() && busylog[i]; i++) blen++;
   endtask

   initial begin
      logic [W-1:0] d;
      logic         p, stp;
      int           from, ns, s, blen, n;
      vecs[0] = '{8'h55, 1'b0};
      vecs[1] = '{8'h01, 1'b1};
      vecs[2] = '{8'hAA, 1'b0};
      vecs[3] = '{8'h0F, 1'b0};
      vecs[4] = '{8'h80, 1'b1};
      vecs[5] = '{8'h7F, 1'b1};
      vecs[6] = '{8'hFF, 1'b0};
      vecs[7] = '{8'h00, 1'b0};

      reset = 1'b1;
      run(3);
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_strobe", q_out_strobe, 0);
      reset = 1'b0;
      run(50);
      chk("idle_strobes", strobes.size(), 0);

      cts_n = 1'b0;
      for (int v = 0; v < 8; v++) begin
         from = txlog.size();
         ns = strobes.size();
         fifo.push_back(vecs[v].word);
         sync_q();
         run(F + 10);
         decode(from, d, p, stp, s, blen);
         chk("vec_data", d, vecs[v].word);
         chk("vec_stop", stp, 1);
         chk("vec_frame_len", blen, F);
         chk("vec_one_strobe", strobes.size() - ns, 1);
`ifdef UART_TX_PARITY_EN
         chk("vec_parity", p, vecs[v].par);
`endif
      end

      from = txlog.size();
      ns = strobes.size();
      fifo.push_back(8'hAA);
      fifo.push_back(8'h0F);
      sync_q();
      run(2 * F + 10);
      chk("two_strobes", strobes.size() - ns, 2);
      chk("two_spacing", strobes.size() >= ns + 2 ? strobes[ns+1] - strobes[ns] : -1, F + 1);
      decode(from, d, p, stp, s, blen);
      chk("two_first", d, 8'hAA);
      decode(s + F, d, p, stp, s, blen);
      chk("two_second", d, 8'h0F);

      cts_n = 1'b1;
      ns = strobes.size();
      fifo.push_back(8'hC3);
      sync_q();
      run(10);
      chk("cts_hold", strobes.size() - ns, 0);
      cts_n = 1'b0;
      #1;
      chk("cts_release", q_out_strobe, 1);
      from = txlog.size();
      run(3 * CD);
      cts_n = 1'b1;
      run(F);
      decode(from, d, p, stp, s, blen);
      chk("cts_mid_len", blen, F);
      chk("cts_mid_data", d, 8'hC3);
      cts_n = 1'b0;
      run(5);

      ns = strobes.size();
      fifo.push_back(8'h3C);
      fifo.push_back(8'h5A);
      sync_q();
      n = 0;
      while (strobes.size() == ns && n < 20) begin
         cyc();
         n++;
      end
      chk("rst_pop_seen", strobes.size() - ns, 1);
      run(3 * CD);
      reset = 1'b1;
      cts_n = 1'b1;
      cyc();
      chk("rst_mid_txd", txd, 1);
      chk("rst_mid_busy", busy, 0);
      reset = 1'b0;
      run(5);
      chk("rst_fifo_cnt", fifo.size(), 1);
      chk("rst_no_extra", strobes.size() - ns, 1);
      cts_n = 1'b0;
      from = txlog.size();
      run(F + 5);
      decode(from, d, p, stp, s, blen);
      chk("rst_next_word", d, 8'h5A);

      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 3) == 0 && fifo.size() < 4) fifo.push_back(W'($urandom));
         if ($urandom_range(0, 15) == 0) cts_n = ~cts_n;
         reset = $urandom_range(0, 499) == 0;
         sync_q();
         cyc();
      end
      reset = 1'b0;
      cts_n = 1'b0;
      n = 0;
      while ((fifo.size() != 0 || rem != 0) && n < 20 * F) begin
         cyc();
         n++;
      end
      chk("drain_fifo", fifo.size(), 0);
      chk("drain_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
